// File: rtl/outpkt_pack64.sv
// Packs a 16-bit packet word stream into zero-padded 64-bit words for the output FIFO.
// Optional idle-timeout flush of partial words: define OUTPKT_PACK_FLUSH_TIMEOUT_EN.
module outpkt_pack64 #(
  parameter int FLUSH_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] din,
  input  logic        pkt_end,
  input  logic        wr_en,
  output logic        full,
  output logic [63:0] dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic        idle
);

  // Lane 3 is only used to park a completed word while the output register is busy (cnt==4).
  logic [3:0][15:0] acc_q, acc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [63:0]      dout_q, dout_d;
  logic             out_valid_q, out_valid_d;

  logic             reg_free, wr_ok, complete, flush;
  logic [3:0][15:0] cpl_word;

  assign full      = (cnt_q == 3'd4);
  assign out_wr_en = out_valid_q & ~out_full;
  assign reg_free  = ~out_valid_q | out_wr_en;
  assign idle      = (cnt_q == 3'd0) & ~out_valid_q;
  assign dout      = dout_q;
  assign wr_ok     = wr_en & ~full;

`ifdef OUTPKT_PACK_FLUSH_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;
  logic        idle_cyc;

  assign idle_cyc = ~wr_en & (cnt_q != 3'd0) & (cnt_q != 3'd4);
  assign flush    = idle_cyc & (timer_q == 16'(FLUSH_TIMEOUT - 1));
  assign timer_d  = (idle_cyc & ~flush) ? timer_q + 16'd1 : 16'd0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  // Timer not built; the comparison keeps the parameter referenced and is always false.
  assign flush = (FLUSH_TIMEOUT < 0);
`endif

  assign complete = (wr_ok & ((cnt_q == 3'd3) | pkt_end)) | flush;

  // Lanes below cnt come from the accumulator, the written lane from din, the rest are zero.
  always_comb begin
    cpl_word = '0;
    for (int l = 0; l < 4; l++) begin
      if (3'(l) < cnt_q)                 cpl_word[l] = acc_q[l];
      else if (3'(l) == cnt_q && wr_ok)  cpl_word[l] = din;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    out_valid_d = out_wr_en ? 1'b0 : out_valid_q;
    if (full) begin
      if (reg_free) begin
        dout_d      = acc_q;
        out_valid_d = 1'b1;
        cnt_d       = 3'd0;
      end
    end else if (complete) begin
      if (reg_free) begin
        dout_d      = cpl_word;
        out_valid_d = 1'b1;
        cnt_d       = 3'd0;
      end else begin
        acc_d = cpl_word;
        cnt_d = 3'd4;
      end
    end else if (wr_ok) begin
      acc_d[cnt_q[1:0]] = din;
      cnt_d             = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
